// File: rtl/gray_frame_buffer.sv
// Single-frame grayscale buffer: captures N*M bytes from the grayscale stage,
// then streams them out in capture order, one byte per downstream request.
module gray_frame_buffer #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       GB_enable,
  input  logic       GS_valid,
  input  logic [7:0] Din,
  input  logic       rd_req,
  output logic [7:0] Dout,
  output logic       GB_valid,
  output logic       full,
  output logic       GB_done,
  output logic       overflow
);
  localparam int F  = N * M;
  localparam int AW = (F > 1) ? $clog2(F) : 1;
  localparam logic [AW-1:0] LAST = AW'(F - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = AW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READY = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [7:0]    dout_q, dout_d;
  logic          gb_valid_q, gb_valid_d;
  logic          full_q, full_d;
  logic          gb_done_q, gb_done_d;
  logic          overflow_q, overflow_d;
  logic          mem_we_s;
  logic [7:0]    mem [F];

  // Next-state, pointer and output computation for the capture/readout controller.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    dout_d     = dout_q;
    gb_valid_d = 1'b0;
    gb_done_d  = 1'b0;
    overflow_d = overflow_q;
    mem_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        rp_d = ZERO;
        if (GB_enable) begin
          // A byte arriving with the enable edge is already part of the frame.
          state_d = WRITE;
          if (GS_valid) begin
            mem_we_s = 1'b1;
            wp_d     = ONE;
          end else begin
            wp_d = ZERO;
          end
        end else begin
          state_d = IDLE;
          wp_d    = ZERO;
        end
      end
      WRITE: begin
        if (!GB_enable) begin
          state_d = IDLE;
          wp_d    = ZERO;
          rp_d    = ZERO;
        end else if (GS_valid) begin
          mem_we_s = 1'b1;
          if (wp_q == LAST) begin
            state_d = READY;
            wp_d    = ZERO;
          end else begin
            wp_d = wp_q + ONE;
          end
        end else begin
          wp_d = wp_q;
        end
      end
      READY, READ: begin
        // Bytes arriving while a frame is held are dropped and flagged.
        overflow_d = overflow_q | GS_valid;
        if (!GB_enable) begin
          state_d = IDLE;
          wp_d    = ZERO;
          rp_d    = ZERO;
        end else if (rd_req) begin
          dout_d     = mem[rp_q];
          gb_valid_d = 1'b1;
          if (rp_q == LAST) begin
            state_d   = IDLE;
            rp_d      = ZERO;
            gb_done_d = 1'b1;
          end else begin
            state_d = READ;
            rp_d    = rp_q + ONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        wp_d    = ZERO;
        rp_d    = ZERO;
      end
    endcase
    full_d = (state_d == READY) || (state_d == READ);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wp_q       <= ZERO;
      rp_q       <= ZERO;
      dout_q     <= 8'h00;
      gb_valid_q <= 1'b0;
      full_q     <= 1'b0;
      gb_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      dout_q     <= dout_d;
      gb_valid_q <= gb_valid_d;
      full_q     <= full_d;
      gb_done_q  <= gb_done_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage; contents are only meaningful once a frame has been captured.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wp_q] <= Din;
    end
  end

  assign Dout     = dout_q;
  assign GB_valid = gb_valid_q;
  assign full     = full_q;
  assign GB_done  = gb_done_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_gray_frame_buffer.sv
// Directed-plus-random bench for gray_frame_buffer; expected values come from
// the frame contents the bench itself sends and the order it requests them.
module tb_gray_frame_buffer;
  localparam int N = 2;
  localparam int M = 2;
  localparam int F = N * M;

  logic       clk = 1'b0;
  logic       rst;
  logic       GB_enable;
  logic       GS_valid;
  logic [7:0] Din;
  logic       rd_req;
  logic [7:0] Dout;
  logic       GB_valid;
  logic       full;
  logic       GB_done;
  logic       overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] exp_mem [F];
  logic [7:0] last_dout;
  logic       exp_ovf;

  gray_frame_buffer #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .GB_enable(GB_enable),
    .GS_valid (GS_valid),
    .Din      (Din),
    .rd_req   (rd_req),
    .Dout     (Dout),
    .GB_valid (GB_valid),
    .full     (full),
    .GB_done  (GB_done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic new_frame();
    for (int i = 0; i < F; i++) exp_mem[i] = 8'($urandom);
  endtask

  // Sends exp_mem in order with up to max_gap idle (garbage-Din) cycles before each byte.
  task automatic fill_frame(input int max_gap);
    for (int i = 0; i < F; i++) begin
      int gaps;
      gaps = int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gaps; g++) begin
        GS_valid = 1'b0;
        Din      = 8'($urandom);
        step();
        check1("fill_gap_full", full, 1'b0);
      end
      GS_valid = 1'b1;
      Din      = exp_mem[i];
      step();
      check1("fill_full", full, (i == F - 1));
      check1("fill_valid", GB_valid, 1'b0);
    end
    GS_valid = 1'b0;
    Din      = 8'd0;
    check1("fill_ovf", overflow, exp_ovf);
  endtask

  // Drains the frame; pattern bits (MSB first) drive rd_req for the first 6 cycles.
  task automatic read_frame(input logic [5:0] pat, input bit use_pat, input int gs_pct);
    int k;
    k = 0;
    for (int c = 0; k < F; c++) begin
      logic r;
      if (use_pat && c < 6) r = pat[5 - c];
      else if (c >= 20) r = 1'b1;
      else r = 1'($urandom_range(1, 0));
      rd_req   = r;
      GS_valid = (int'($urandom_range(99, 0)) < gs_pct);
      Din      = 8'($urandom);
      if (GS_valid) exp_ovf = 1'b1;
      step();
      if (r) begin
        last_dout = exp_mem[k];
        check1("rd_valid", GB_valid, 1'b1);
        check8("rd_dout", Dout, last_dout);
        check1("rd_done", GB_done, (k == F - 1));
        check1("rd_full", full, (k != F - 1));
        k++;
      end else begin
        check1("pause_valid", GB_valid, 1'b0);
        check8("pause_dout", Dout, last_dout);
        check1("pause_done", GB_done, 1'b0);
        check1("pause_full", full, 1'b1);
      end
      check1("rd_ovf", overflow, exp_ovf);
    end
    rd_req   = 1'b0;
    GS_valid = 1'b0;
    step();
    check1("post_rd_valid", GB_valid, 1'b0);
    check1("post_rd_done", GB_done, 1'b0);
    check1("post_rd_full", full, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    GB_enable = 1'b0;
    GS_valid  = 1'b0;
    rd_req    = 1'b0;
    Din       = 8'd0;
    exp_ovf   = 1'b0;
    last_dout = 8'd0;
    #2;
    check8("rst_dout", Dout, 8'h00);
    check1("rst_valid", GB_valid, 1'b0);
    check1("rst_full", full, 1'b0);
    check1("rst_done", GB_done, 1'b0);
    check1("rst_ovf", overflow, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();

    // Back-to-back fill, first byte together with the enable edge, continuous drain.
    exp_mem   = '{8'd10, 8'd20, 8'd30, 8'd40};
    GB_enable = 1'b1;
    fill_frame(0);
    read_frame(6'b111111, 1'b1, 0);

    // Gapped fill, overflow while holding the frame, paused drain.
    exp_mem = '{8'd5, 8'd6, 8'd7, 8'd8};
    fill_frame(2);
    GS_valid = 1'b1;
    Din      = 8'hFF;
    exp_ovf  = 1'b1;
    step();
    GS_valid = 1'b0;
    check1("ovf_set", overflow, 1'b1);
    check1("ovf_full", full, 1'b1);
    check1("ovf_valid", GB_valid, 1'b0);
    step();
    check1("ovf_sticky", overflow, 1'b1);
    read_frame(6'b100111, 1'b1, 0);

    // Random frames, random request gaps, random inbound bytes during readout.
    for (int f = 0; f < 3; f++) begin
      new_frame();
      fill_frame(3);
      read_frame(6'd0, 1'b0, 30);
    end

    // Abort after two bytes, stray byte while disabled, then a fresh frame.
    new_frame();
    GS_valid = 1'b1;
    Din      = exp_mem[0];
    step();
    Din = exp_mem[1];
    step();
    GS_valid  = 1'b0;
    GB_enable = 1'b0;
    step();
    check1("abort_w_full", full, 1'b0);
    check1("abort_w_valid", GB_valid, 1'b0);
    GS_valid = 1'b1;
    Din      = 8'h99;
    step();
    GS_valid = 1'b0;
    check1("idle_stray_full", full, 1'b0);
    check1("idle_stray_ovf", overflow, exp_ovf);
    GB_enable = 1'b1;
    exp_mem   = '{8'd1, 8'd2, 8'd3, 8'd4};
    fill_frame(0);
    read_frame(6'b111111, 1'b1, 0);

    // Abort during readout: no completion pulse, frame released.
    new_frame();
    fill_frame(1);
    rd_req = 1'b1;
    step();
    last_dout = exp_mem[0];
    check1("abort_r_first_valid", GB_valid, 1'b1);
    check8("abort_r_first_dout", Dout, last_dout);
    GB_enable = 1'b0;
    step();
    check1("abort_r_valid", GB_valid, 1'b0);
    check1("abort_r_done", GB_done, 1'b0);
    check1("abort_r_full", full, 1'b0);
    rd_req = 1'b0;
    step();
    check1("abort_r_idle_full", full, 1'b0);
    check1("abort_r_idle_valid", GB_valid, 1'b0);
    GB_enable = 1'b1;

    // Asynchronous reset between clock edges in the middle of a readout.
    new_frame();
    fill_frame(0);
    rd_req = 1'b1;
    step();
    check8("pre_rst_dout", Dout, exp_mem[0]);
    rd_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check8("arst_dout", Dout, 8'h00);
    check1("arst_valid", GB_valid, 1'b0);
    check1("arst_full", full, 1'b0);
    check1("arst_done", GB_done, 1'b0);
    check1("arst_ovf", overflow, 1'b0);
    exp_ovf   = 1'b0;
    last_dout = 8'h00;
    #1;
    rst = 1'b0;
    new_frame();
    fill_frame(1);
    read_frame(6'd0, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/gray_frame_buffer.md
GRAY_FRAME_BUFFER -- requirements
Module: gray_frame_buffer

Interface
REQ-001 SHALL have parameter N, default 2, image height in pixels.
REQ-002 SHALL have parameter M, default 2, image width in pixels; frame size F = N*M bytes, F >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port GB_enable  input  1  controller enable; low forces return to IDLE.
REQ-006 SHALL have port GS_valid  input  1  upstream grayscale byte present on Din this cycle.
REQ-007 SHALL have port Din  input  8  grayscale byte from grayscale stage.
REQ-008 SHALL have port rd_req  input  1  downstream request for next stored byte.
REQ-009 SHALL have port Dout  output  8  registered read data.
REQ-010 SHALL have port GB_valid  output  1  Dout holds a valid byte this cycle.
REQ-011 SHALL have port full  output  1  frame completely captured, readout not finished.
REQ-012 SHALL have port GB_done  output  1  one-cycle pulse after last byte read out.
REQ-013 SHALL have port overflow  output  1  sticky flag: a byte arrived when it could not be stored.

Function
REQ-014 SHALL hold an internal F x 8-bit storage array, write pointer wp and read pointer rp, each ceil(log2 F) bits wide.
REQ-015 SHALL implement FSM states IDLE, WRITE, READY, READ (registered state, combinational next-state).
REQ-016 IDLE: wp=rp=0; GB_enable=1 -> WRITE next cycle; a GS_valid in the same cycle as enable rising SHALL be stored (treated as WRITE cycle).
REQ-017 WRITE: each cycle with GS_valid=1, mem[wp] <= Din, wp <= wp+1; no write when GS_valid=0.
REQ-018 WRITE: write at wp=F-1 -> READY next cycle, wp returns to 0 (no wrap beyond F).
REQ-019 READY: full=1; rd_req=1 -> READ; stays indefinitely otherwise.
REQ-020 READ: each cycle with rd_req=1, Dout <= mem[rp], GB_valid=1 on the following cycle, rp <= rp+1; latency rd_req to data = 1 cycle.
REQ-021 READ: rd_req=0 -> GB_valid=0 next cycle, Dout holds last value, rp unchanged (pause).
REQ-022 READ: read issued at rp=F-1 -> last byte valid next cycle, GB_done=1 in that same cycle, full=0, state -> IDLE.
REQ-023 full SHALL be 1 exactly in READY and READ states, 0 elsewhere.
REQ-024 GS_valid=1 in READY or READ SHALL not alter storage and SHALL set overflow=1; overflow clears only on rst.
REQ-025 GB_enable=0 in WRITE, READY or READ SHALL abort to IDLE next cycle: pointers 0, full=0, GB_valid=0, no GB_done; storage contents unspecified.
REQ-026 GS_valid and rd_req simultaneously in READ: read proceeds, overflow set, storage unchanged.
REQ-027 No combinational path from Din or GS_valid to any output.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, wp=rp=0, Dout=8'h00, GB_valid=0, full=0, GB_done=0, overflow=0, regardless of clk.
REQ-029 rst asserted mid-WRITE or mid-READ SHALL discard the partial frame; first post-reset frame SHALL store from address 0.
REQ-030 Storage array contents SHALL not require reset.

Verification
REQ-031 Fill/drain: N=M=2, enable, GS_valid with Din=10,20,30,40 -> full=1 after 4th byte; hold rd_req=1 -> Dout 10,20,30,40 on 4 consecutive cycles with GB_valid=1, GB_done pulse with 40, full=0.
REQ-032 Gapped input: bytes 5,_,6,_,_,7,8 (GS_valid low in gaps) -> stored 5,6,7,8 only; full asserts cycle after byte 8.
REQ-033 Paused read: rd_req pattern 1,0,0,1,1,1 -> GB_valid 0,1,0,0,1,1,1; Dout held at first byte during pause; exactly 4 valid bytes.
REQ-034 Overflow: in READY, GS_valid=1 Din=8'hFF -> overflow=1 sticky, readout still 10,20,30,40.
REQ-035 Abort: GB_enable low after 2 bytes -> IDLE, full=0; new frame 1,2,3,4 reads back 1,2,3,4.
REQ-036 Async reset: rst pulse between clock edges during READ -> all outputs zero before next clk edge, overflow=0.
